// File: rtl/abc_sweep_pkg.sv
// Shared types and helpers for the ABC truth-table sweep controller.
// The priority encoder lives here because it is the only reusable piece of logic.
package abc_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;

  // Lowest set bit wins; an all-zero input yields index 0.
  function automatic logic [VEC_W-1:0] lowest_set_idx(input logic [NUM_VECTORS-1:0] v);
    lowest_set_idx = '0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set_idx = VEC_W'(i);
    end
  endfunction

endpackage

// File: rtl/abc_sweep_ctrl.sv
// Self-test sequencer: steps {C,B,A} through 0..7, samples Y after a settle
// interval, and grades the captured truth table against EXPECTED_TT.
module abc_sweep_ctrl
  import abc_sweep_pkg::*;
#(
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0] EXPECTED_TT   = 8'hE8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic [VEC_W-1:0]       dut_abc,
  input  logic                   dut_y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   aborted,
  output logic [VEC_W-1:0]       first_fail,
  output logic [NUM_VECTORS-1:0] result
);

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] IDX_LAST = VEC_W'(NUM_VECTORS - 1);

  state_t                 state;
  logic [VEC_W-1:0]       idx;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_VECTORS-1:0] final_result;

  // The last vector's bit is graded in the same cycle it is captured, so
  // pass/first_fail see it through this bypass rather than through result.
  always_comb begin
    final_result                  = result;
    final_result[NUM_VECTORS - 1] = dut_y;
  end

  // NOTE: all state, including the result register, is cleared by the
  // synchronous reset and updated only with non-blocking assignments, so every
  // output is a clean register with no same-cycle ordering hazards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      dut_abc    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      aborted    <= 1'b0;
      first_fail <= '0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state      <= SETTLE;
            idx        <= '0;
            cnt        <= '0;
            dut_abc    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            aborted    <= 1'b0;
            first_fail <= '0;
            result     <= '0;
          end
        end

        SETTLE: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            dut_abc <= '0;
            aborted <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (abort) begin
            // Abort beats the capture: the bit under test is left unwritten.
            state   <= IDLE;
            busy    <= 1'b0;
            dut_abc <= '0;
            aborted <= 1'b1;
          end else begin
            result[idx] <= dut_y;
            if (idx == IDX_LAST) begin
              state      <= IDLE;
              busy       <= 1'b0;
              dut_abc    <= '0;
              done       <= 1'b1;
              pass       <= (final_result == EXPECTED_TT);
              first_fail <= lowest_set_idx(final_result ^ EXPECTED_TT);
            end else begin
              state   <= SETTLE;
              idx     <= idx + 1'b1;
              dut_abc <= idx + 1'b1;
              cnt     <= '0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_abc_sweep_ctrl.sv
// Self-checking bench for abc_sweep_ctrl: constant vector table, hand-written
// corner sequences, and randomized sweeps graded by a timing/arithmetic model.
module tb_abc_sweep_ctrl;

  localparam int          S     = 2;
  localparam int          P     = S + 1;
  localparam int          SWEEP = 8 * P;
  localparam logic [7:0]  EXP   = 8'hE8;

  logic       clk = 1'b0;
  logic       rst, start, abort, dut_y;
  logic [2:0] dut_abc, first_fail;
  logic       busy, done, pass, aborted;
  logic [7:0] result;
  logic [7:0] model_tt;

  int total = 0;
  int bad   = 0;

  abc_sweep_ctrl #(.SETTLE_CYCLES(S), .EXPECTED_TT(EXP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .dut_abc    (dut_abc),
    .dut_y      (dut_y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .aborted    (aborted),
    .first_fail (first_fail),
    .result     (result)
  );

  always #5 clk = ~clk;

  // The "simple circuit" is just a lookup of its truth table.
  assign dut_y = model_tt[dut_abc];

  typedef struct {
    logic [7:0] tt;
    int         abort_at;
    logic [7:0] res;
    bit         d;
    bit         p;
    bit         a;
    logic [2:0] ff;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] res, input bit d,
                               input bit p, input bit a, input logic [2:0] ff);
    check({tag, ".busy"},       32'(busy),       32'(0));
    check({tag, ".dut_abc"},    32'(dut_abc),    32'(0));
    check({tag, ".done"},       32'(done),       32'(d));
    check({tag, ".pass"},       32'(pass),       32'(p));
    check({tag, ".aborted"},    32'(aborted),    32'(a));
    check({tag, ".first_fail"}, 32'(first_fail), 32'(ff));
    check({tag, ".result"},     32'(result),     32'(res));
  endtask

  // Edge k is counted from the edge that captured start. Before edge k the
  // drive should show vector (k-1)/P with busy high.
  task automatic sweep(input logic [7:0] tt, input int abort_at, input int start_at);
    model_tt = tt;
    start    = 1'b1;
    abort    = 1'b0;
    step();
    start = 1'b0;
    for (int k = 1; k <= SWEEP; k++) begin
      check("path.dut_abc", 32'(dut_abc), 32'((k - 1) / P));
      check("path.busy",    32'(busy),    32'(1));
      abort = (k == abort_at);
      start = (k == start_at);
      step();
      abort = 1'b0;
      start = 1'b0;
      if (k == abort_at) break;
    end
  endtask

  // Reference: vectors are sampled on edges P, 2P, ... 8P; an abort on edge k
  // keeps only the samples taken strictly before it.
  task automatic predict(input logic [7:0] tt, input int abort_at, output logic [7:0] res,
                         output bit d, output bit p, output bit a, output logic [2:0] ff);
    res = '0;
    ff  = '0;
    if (abort_at >= 1 && abort_at <= SWEEP) begin
      for (int i = 0; i < (abort_at - 1) / P; i++) res[i] = tt[i];
      d = 1'b0;
      p = 1'b0;
      a = 1'b1;
    end else begin
      res = tt;
      d   = 1'b1;
      a   = 1'b0;
      p   = (tt == EXP);
      for (int i = 7; i >= 0; i--) if (res[i] != EXP[i]) ff = 3'(i);
    end
  endtask

  initial begin
    logic [7:0] e_res;
    bit         e_d, e_p, e_a;
    logic [2:0] e_ff;
    int         ab;

    vecs[0] = '{8'hE8, 0,  8'hE8, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[1] = '{8'h88, 0,  8'h88, 1'b1, 1'b0, 1'b0, 3'd5};
    vecs[2] = '{8'h00, 0,  8'h00, 1'b1, 1'b0, 1'b0, 3'd3};
    vecs[3] = '{8'hFF, 0,  8'hFF, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[4] = '{8'h68, 0,  8'h68, 1'b1, 1'b0, 1'b0, 3'd7};
    vecs[5] = '{8'hE9, 0,  8'hE9, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[6] = '{8'hE8, 10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[7] = '{8'hE8, 13, 8'h08, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[8] = '{8'hE8, 1,  8'h00, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[9] = '{8'hE8, 24, 8'h68, 1'b0, 1'b0, 1'b1, 3'd0};

    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    model_tt = EXP;
    step();
    step();
    rst = 1'b0;
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

    abort = 1'b1;
    step();
    abort = 1'b0;
    check_outputs("idle_abort", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);

    foreach (vecs[i]) begin
      sweep(vecs[i].tt, vecs[i].abort_at, 0);
      check_outputs($sformatf("vec%0d", i), vecs[i].res, vecs[i].d, vecs[i].p,
                    vecs[i].a, vecs[i].ff);
    end

    // Last table row aborted on the final sample; start+abort must not clear it.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_outputs("idle_start_abort_after_abort", 8'h68, 1'b0, 1'b0, 1'b1, 3'd0);

    // start during busy at idx 2 is ignored, then start+abort in IDLE too.
    sweep(EXP, 0, 7);
    check_outputs("restart_ignored", EXP, 1'b1, 1'b1, 1'b0, 3'd0);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_outputs("idle_start_abort_after_done", EXP, 1'b1, 1'b1, 1'b0, 3'd0);

    // Reset in the SAMPLE cycle of idx 5, then a clean sweep.
    model_tt = EXP;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 17; k++) step();
    check("mid_rst.dut_abc", 32'(dut_abc), 32'(5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outputs("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    sweep(EXP, 0, 0);
    check_outputs("after_rst", EXP, 1'b1, 1'b1, 1'b0, 3'd0);

    for (int n = 0; n < 24; n++) begin
      model_tt = 8'($urandom);
      if (n % 4 == 0) model_tt = EXP;
      ab = int'($urandom_range(0, SWEEP + 6));
      predict(model_tt, ab, e_res, e_d, e_p, e_a, e_ff);
      sweep(model_tt, ab, 0);
      check_outputs($sformatf("rand%0d", n), e_res, e_d, e_p, e_a, e_ff);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
